// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; 1-cycle latency for single-step ops,
// k cycles after acceptance for k-bit shifts (one bit per cycle); holds the result while out_ready is low.
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_NAND  = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHR   = 4'b0101;
  localparam logic [3:0] OP_OUT   = 4'b0110;
  localparam logic [3:0] OP_IN    = 4'b0111;
  localparam logic [3:0] OP_MOV   = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [3:0]         flags_q, flags_d;
  logic               vld_q, vld_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   nand_r, shifted;
  logic               out_bit, accept, v_add, v_sub;

  function automatic logic [1:0] zn(input logic [WIDTH-1:0] r);
    return {r == '0, r[WIDTH-1]};
  endfunction

  assign shamt   = B[SHAMT_W-1:0];
  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} - {1'b0, B};
  assign nand_r  = ~(A & B);
  assign v_add   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign v_sub   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  // dir_q=1 means shift right; the bit leaving the register becomes C
  assign shifted = dir_q ? {1'b0, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
  assign out_bit = dir_q ? work_q[0] : work_q[WIDTH-1];

  assign in_ready  = !rst && (state_q == IDLE) && (!vld_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_q;
  assign Y         = y_q;
  assign flags     = flags_q;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    flags_d = flags_q;
    vld_d   = vld_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (vld_q && out_ready) vld_d = 1'b0;
        if (accept) begin
          vld_d = 1'b1;
          case (sel)
            OP_ADD: begin
              y_d     = sum[WIDTH-1:0];
              flags_d = {zn(sum[WIDTH-1:0]), sum[WIDTH], v_add};
            end
            OP_SUB: begin
              y_d     = diff[WIDTH-1:0];
              flags_d = {zn(diff[WIDTH-1:0]), ~diff[WIDTH], v_sub};
            end
            OP_NAND: begin
              y_d     = nand_r;
              flags_d = {zn(nand_r), 2'b00};
            end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                y_d     = A;
                flags_d = {zn(A), 2'b00};
              end else begin
                vld_d   = 1'b0;
                work_d  = A;
                cnt_d   = shamt;
                dir_d   = (sel == OP_SHR);
                state_d = SHIFT;
              end
            end
            OP_OUT, OP_STORE: y_d = A;
            OP_MOV:           y_d = B;
            OP_IN:            y_d = '0;
            default:          y_d = '0;
          endcase
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          y_d     = shifted;
          flags_d = {zn(shifted), out_bit, 1'b0};
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      flags_q <= '0;
      vld_q   <= 1'b0;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      vld_q   <= vld_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: transaction-level model checked every cycle on the 8-bit instance,
// directed literal checks on both the 8-bit and 16-bit instances.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [7:0] A, B;
  logic [3:0] sel;
  logic       in_ready, out_valid;
  logic [7:0] Y;
  logic [3:0] flags;

  logic        w_in_valid, w_out_ready;
  logic [15:0] w_A, w_B;
  logic [3:0]  w_sel;
  logic        w_in_ready, w_out_valid;
  logic [15:0] w_Y;
  logic [3:0]  w_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .flags(flags)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .A(w_A), .B(w_B), .sel(w_sel), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .Y(w_Y), .flags(w_flags)
  );

  // Result {Y, Z, N, C, V} of one operation from plain integer arithmetic.
  function automatic logic [11:0] model_op(input logic [3:0] op, input logic [7:0] a, b,
                                           input logic [3:0] f_prev);
    int ua, ub, sa, sb, r, k;
    logic [7:0] y;
    logic [3:0] f;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); k = ub % 8;
    f = f_prev; y = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      4'd1: begin r = ua + ub; y = r[7:0]; c = (r > 255);
                  v = (sa + sb > 127) || (sa + sb < -128); f = {y == 0, y[7], c, v}; end
      4'd2: begin r = ua - ub; y = r[7:0]; c = (ua >= ub);
                  v = (sa - sb > 127) || (sa - sb < -128); f = {y == 0, y[7], c, v}; end
      4'd3: begin y = ~(a & b); f = {y == 0, y[7], 2'b00}; end
      4'd4: begin r = ua << k; y = r[7:0]; c = (k != 0) && (((ua >> (8 - k)) & 1) == 1);
                  f = {y == 0, y[7], c, 1'b0}; end
      4'd5: begin r = ua >> k; y = r[7:0]; c = (k != 0) && (((ua >> (k - 1)) & 1) == 1);
                  f = {y == 0, y[7], c, 1'b0}; end
      4'd6, 4'd9: y = a;
      4'd8:       y = b;
      default:    y = 8'h00;
    endcase
    return {y, f};
  endfunction

  logic        m_valid;
  logic [7:0]  m_y;
  logic [3:0]  m_f;
  logic [11:0] m_pend, m_res;
  int          m_busy;
  logic        m_ready, m_long;

  assign m_res   = model_op(sel, A, B, m_f);
  assign m_long  = (sel == 4'd4 || sel == 4'd5) && (B[2:0] != 3'd0);
  assign m_ready = !rst && (m_busy == 0) && (!m_valid || out_ready);

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0; m_y <= 8'h00; m_f <= 4'h0; m_busy <= 0; m_pend <= 12'h000;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_valid <= 1'b1; m_y <= m_pend[11:4]; m_f <= m_pend[3:0];
      end
    end else if (in_valid && m_ready) begin
      if (m_long) begin
        m_busy <= int'(B[2:0]); m_pend <= m_res; m_valid <= 1'b0;
      end else begin
        m_valid <= 1'b1; m_y <= m_res[11:4]; m_f <= m_res[3:0];
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk); #1;
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_in_ready", 32'(in_ready), 32'(m_ready));
      chk("cyc_Y", 32'(Y), 32'(m_y));
      chk("cyc_flags", 32'(flags), 32'(m_f));
    end
  end

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic send(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    int n;
    sel = s; A = a; B = b; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, input int lat, input logic [7:0] ey,
                          input logic [3:0] ef);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_Y"}, 32'(Y), 32'(ey));
    chk({nm, "_flags"}, 32'(flags), 32'(ef));
  endtask

  localparam int NV = 13;
  logic [3:0] t_op [NV] = '{4'd2, 4'd3, 4'd1, 4'd4, 4'd0, 4'd6, 4'd9, 4'd7, 4'd15,
                           4'd5, 4'd1, 4'd2, 4'd4};
  logic [7:0] t_a  [NV] = '{8'h80, 8'hFF, 8'hFF, 8'h81, 8'h55, 8'h5A, 8'hA5, 8'h33, 8'h44,
                           8'h80, 8'h80, 8'h00, 8'h01};
  logic [7:0] t_b  [NV] = '{8'h01, 8'hFF, 8'h01, 8'h00, 8'h11, 8'h00, 8'h00, 8'h22, 8'h55,
                           8'hF7, 8'h80, 8'h01, 8'h07};
  logic [7:0] t_y  [NV] = '{8'h7F, 8'h00, 8'h00, 8'h81, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00,
                           8'h01, 8'h00, 8'hFF, 8'h80};
  logic [3:0] t_f  [NV] = '{4'h3, 4'h8, 4'hA, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4,
                           4'h0, 4'hB, 4'h4, 4'h4};
  int         t_lat[NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 7};

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; sel = 4'h0; A = 8'h00; B = 8'h00; out_ready = 1'b1;
    w_in_valid = 1'b0; w_sel = 4'h0; w_A = 16'h0; w_B = 16'h0; w_out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_Y", 32'(Y), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    chk("model_add", 32'(model_op(4'd1, 8'h7F, 8'h01, 4'h0)), 32'h805);
    chk("model_sub", 32'(model_op(4'd2, 8'h05, 8'h05, 4'h0)), 32'h00A);
    chk("model_shl", 32'(model_op(4'd4, 8'h81, 8'h03, 4'hF)), 32'h080);

    send(4'd1, 8'h7F, 8'h01); wait_res("add_7f_01", 0, 8'h80, 4'h5);
    send(4'd2, 8'h05, 8'h05); wait_res("sub_eq", 0, 8'h00, 4'hA);
    send(4'd8, 8'h00, 8'h3C); wait_res("mov", 0, 8'h3C, 4'hA);
    send(4'd4, 8'h81, 8'h03);
    chk("shl_busy_ready", 32'(in_ready), 32'd0);
    wait_res("shl3", 3, 8'h08, 4'h0);
    send(4'd5, 8'h81, 8'h01); wait_res("shr1", 1, 8'h40, 4'h2);

    for (int i = 0; i < NV; i++) begin
      send(t_op[i], t_a[i], t_b[i]);
      wait_res($sformatf("vec%0d", i), t_lat[i], t_y[i], t_f[i]);
    end

    // Backpressure: result held, queued op accepted on the release edge
    tick();
    out_ready = 1'b0;
    send(4'd1, 8'h01, 8'h02);
    chk("bp_first_Y", 32'(Y), 32'h03);
    sel = 4'd2; A = 8'h09; B = 8'h03; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_Y", 32'(Y), 32'h03);
      chk("bp_hold_flags", 32'(flags), 32'h0);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_Y", 32'(Y), 32'h06);
    chk("bp_next_flags", 32'(flags), 32'h2);

    // Back-to-back stream, one op per cycle
    for (int i = 0; i < 4; i++) begin
      sel = 4'd1; A = 8'(17 * i + 1); B = 8'(i + 2); in_valid = 1'b1;
      #1;
      chk("stream_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_Y", 32'(Y), 32'(8'(18 * i + 3)));
    end
    in_valid = 1'b0;
    tick();

    // Reset mid-shift aborts the operation
    send(4'd4, 8'h03, 8'h07);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_Y", 32'(Y), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end

    // 16-bit instance
    w_sel = 4'd1; w_A = 16'hFFFF; w_B = 16'h0001; w_in_valid = 1'b1;
    #1;
    chk("w_add_ready", 32'(w_in_ready), 32'd1);
    tick();
    w_in_valid = 1'b0;
    chk("w_add_valid", 32'(w_out_valid), 32'd1);
    chk("w_add_Y", 32'(w_Y), 32'h0000);
    chk("w_add_flags", 32'(w_flags), 32'hA);
    tick();
    w_sel = 4'd4; w_A = 16'h8000; w_B = 16'h000F; w_in_valid = 1'b1;
    #1;
    chk("w_shl_ready", 32'(w_in_ready), 32'd1);
    tick();
    w_in_valid = 1'b0;
    chk("w_shl_busy", 32'(w_in_ready), 32'd0);
    n = 0;
    while (!w_out_valid && n < 40) begin tick(); n++; end
    chk("w_shl_lat", 32'(n), 32'd15);
    chk("w_shl_Y", 32'(w_Y), 32'h0000);
    chk("w_shl_flags", 32'(w_flags), 32'h8);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
